// File: rtl/bram_loader_pkg.sv
// bram_loader_pkg: loader state type and helpers that derive BRAM widths/depths from the GAT sizing parameters
package bram_loader_pkg;
  typedef enum logic [2:0] {IDLE, LD_H, LD_NI, LD_W, DONE} loader_state_t;
  function automatic int h_data_width(input int data_width, input int num_feature_in);
    return data_width + $clog2(num_feature_in);
  endfunction
  function automatic int node_info_width(input int num_feature_in, input int max_nodes);
    return $clog2(num_feature_in) + $clog2(max_nodes) + 1;
  endfunction
  function automatic int weight_depth(input int num_feature_out, input int num_feature_in);
    return num_feature_out * (num_feature_in + 2);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/bram_loader.sv
// bram_loader: streams one AXIS transfer into the H-data, node-info and weight BRAM write ports in order.
//   clk/rst_n             clock, async active-low reset
//   start                 begins a load from IDLE or DONE; clears done flags and err
//   s_axis_*              input stream, one right-aligned BRAM word per beat, tlast closes each region
//   h_data_bram_*         H-data write port
//   h_node_info_bram_*    node-info write port
//   wgt_bram_*            weight write port
//   *_load_done           sticky per-region completion
//   busy                  loading a region
//   err                   sticky framing error
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int AXIS_W = 32,
  parameter int DATA_WIDTH = 8,
  parameter int H_NUM_SPARSE_DATA = 242101,
  parameter int TOTAL_NODES = 13264,
  parameter int NUM_FEATURE_IN = 1433,
  parameter int NUM_FEATURE_OUT = 16,
  parameter int MAX_NODES = 168,
  localparam int H_DATA_WIDTH = h_data_width(DATA_WIDTH, NUM_FEATURE_IN),
  localparam int NODE_INFO_WIDTH = node_info_width(NUM_FEATURE_IN, MAX_NODES),
  localparam int WEIGHT_DEPTH = weight_depth(NUM_FEATURE_OUT, NUM_FEATURE_IN),
  localparam int H_AW = $clog2(H_NUM_SPARSE_DATA),
  localparam int NI_AW = $clog2(TOTAL_NODES),
  localparam int W_AW = $clog2(WEIGHT_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [AXIS_W-1:0]          s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [H_DATA_WIDTH-1:0]    h_data_bram_din,
  output logic                       h_data_bram_ena,
  output logic                       h_data_bram_wea,
  output logic [H_AW-1:0]            h_data_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0] h_node_info_bram_din,
  output logic                       h_node_info_bram_ena,
  output logic                       h_node_info_bram_wea,
  output logic [NI_AW-1:0]           h_node_info_bram_addra,
  output logic [DATA_WIDTH-1:0]      wgt_bram_din,
  output logic                       wgt_bram_ena,
  output logic                       wgt_bram_wea,
  output logic [W_AW-1:0]            wgt_bram_addra,
  output logic                       h_data_bram_load_done,
  output logic                       h_node_info_bram_load_done,
  output logic                       wgt_bram_load_done,
  output logic                       busy,
  output logic                       err
);
  localparam int CNT_W = $clog2(max3(H_NUM_SPARSE_DATA, TOTAL_NODES, WEIGHT_DEPTH) + 1);
  loader_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, last_idx;
  logic [2:0] sel, wr_q, fin_q, done_q;
  logic accept, at_last, good, bad, fin, start_ok, err_q;
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
  assign busy = state_q inside {LD_H, LD_NI, LD_W};
  assign s_axis_tready = busy;
  assign sel = {state_q == LD_W, state_q == LD_NI, state_q == LD_H};
  assign last_idx = sel[0] ? CNT_W'(H_NUM_SPARSE_DATA - 1) :
                    sel[1] ? CNT_W'(TOTAL_NODES - 1) : CNT_W'(WEIGHT_DEPTH - 1);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign at_last = cnt_q == last_idx;
  // a beat is well framed only when tlast coincides exactly with the region's final word
  assign good = accept && (at_last == s_axis_tlast);
  assign bad = accept && (at_last != s_axis_tlast);
  assign fin = good && at_last;
  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (start_ok) begin
      state_d = LD_H;
      cnt_d = '0;
    end else if (bad) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (fin) begin
      state_d = sel[0] ? LD_NI : sel[1] ? LD_W : DONE;
      cnt_d = '0;
    end else if (good) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= '0;
      fin_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= good ? sel : 3'b000;
      fin_q <= fin ? sel : 3'b000;
      // done lags the final write by one cycle; a fresh start wins over a pending completion
      done_q <= start_ok ? 3'b000 : (done_q | fin_q);
      err_q <= start_ok ? 1'b0 : (err_q | bad);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_data_bram_addra <= '0;
      h_data_bram_din <= '0;
      h_node_info_bram_addra <= '0;
      h_node_info_bram_din <= '0;
      wgt_bram_addra <= '0;
      wgt_bram_din <= '0;
    end else begin
      if (good && sel[0]) begin
        h_data_bram_addra <= cnt_q[H_AW-1:0];
        h_data_bram_din <= s_axis_tdata[H_DATA_WIDTH-1:0];
      end
      if (good && sel[1]) begin
        h_node_info_bram_addra <= cnt_q[NI_AW-1:0];
        h_node_info_bram_din <= s_axis_tdata[NODE_INFO_WIDTH-1:0];
      end
      if (good && sel[2]) begin
        wgt_bram_addra <= cnt_q[W_AW-1:0];
        wgt_bram_din <= s_axis_tdata[DATA_WIDTH-1:0];
      end
    end
  end
  assign h_data_bram_ena = wr_q[0];
  assign h_data_bram_wea = wr_q[0];
  assign h_node_info_bram_ena = wr_q[1];
  assign h_node_info_bram_wea = wr_q[1];
  assign wgt_bram_ena = wr_q[2];
  assign wgt_bram_wea = wr_q[2];
  assign h_data_bram_load_done = done_q[0];
  assign h_node_info_bram_load_done = done_q[1];
  assign wgt_bram_load_done = done_q[2];
  assign err = err_q;
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: randomized and directed load sequences checked every cycle against a behavioural loader model
module tb_bram_loader;
  logic clk = 1'b0;
  logic rst_n, start, s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic [9:0] h_data_bram_din;
  logic [10:0] h_node_info_bram_din;
  logic [7:0] wgt_bram_din;
  logic [1:0] h_data_bram_addra, h_node_info_bram_addra;
  logic [3:0] wgt_bram_addra;
  logic h_data_bram_ena, h_data_bram_wea, h_node_info_bram_ena, h_node_info_bram_wea, wgt_bram_ena, wgt_bram_wea;
  logic h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done, busy, err;
  int errors = 0, checks = 0, wr_cnt = 0;
  int depth[3] = '{4, 3, 12};
  int mask[3] = '{'h3ff, 'h7ff, 'hff};
  int m_reg, m_cnt, m_addr[3], m_din[3];
  logic [2:0] m_wr, m_done, m_pend;
  logic m_err, m_rdy;

  always #5 clk = ~clk;

  bram_loader #(.AXIS_W(32), .DATA_WIDTH(8), .H_NUM_SPARSE_DATA(4), .TOTAL_NODES(3),
                .NUM_FEATURE_IN(4), .NUM_FEATURE_OUT(2), .MAX_NODES(168)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .h_data_bram_din(h_data_bram_din), .h_data_bram_ena(h_data_bram_ena),
    .h_data_bram_wea(h_data_bram_wea), .h_data_bram_addra(h_data_bram_addra),
    .h_node_info_bram_din(h_node_info_bram_din), .h_node_info_bram_ena(h_node_info_bram_ena),
    .h_node_info_bram_wea(h_node_info_bram_wea), .h_node_info_bram_addra(h_node_info_bram_addra),
    .wgt_bram_din(wgt_bram_din), .wgt_bram_ena(wgt_bram_ena),
    .wgt_bram_wea(wgt_bram_wea), .wgt_bram_addra(wgt_bram_addra),
    .h_data_bram_load_done(h_data_bram_load_done), .h_node_info_bram_load_done(h_node_info_bram_load_done),
    .wgt_bram_load_done(wgt_bram_load_done), .busy(busy), .err(err));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: region -1 idle, 0..2 loading H/NI/W, 3 done; outputs reflect the previous edge's decisions.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_reg = -1; m_cnt = 0; m_wr = 0; m_done = 0; m_pend = 0; m_err = 0;
      for (int i = 0; i < 3; i++) begin m_addr[i] = 0; m_din[i] = 0; end
    end else begin
      m_done = m_done | m_pend;
      m_pend = 0;
      m_wr = 0;
      if (start && (m_reg == -1 || m_reg == 3)) begin
        m_reg = 0; m_cnt = 0; m_done = 0; m_err = 0;
      end else if (s_axis_tvalid && m_reg >= 0 && m_reg <= 2) begin
        if ((m_cnt == depth[m_reg] - 1) != s_axis_tlast) begin
          m_err = 1; m_reg = -1; m_cnt = 0;
        end else begin
          m_wr[m_reg] = 1;
          m_addr[m_reg] = m_cnt;
          m_din[m_reg] = s_axis_tdata & mask[m_reg];
          if (s_axis_tlast) begin
            m_pend[m_reg] = 1; m_reg = m_reg + 1; m_cnt = 0;
          end else m_cnt++;
        end
      end
    end
  end
  assign m_rdy = m_reg >= 0 && m_reg <= 2;

  always @(negedge clk) begin
    chk("ctrl", {26'd0, s_axis_tready, busy, err, wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done},
        {26'd0, m_rdy, m_rdy, m_err, m_done});
    chk("wr", {26'd0, wgt_bram_ena, wgt_bram_wea, h_node_info_bram_ena, h_node_info_bram_wea, h_data_bram_ena, h_data_bram_wea},
        {26'd0, m_wr[2], m_wr[2], m_wr[1], m_wr[1], m_wr[0], m_wr[0]});
    if (m_wr[0]) begin chk("h_addr", 32'(h_data_bram_addra), m_addr[0]); chk("h_din", 32'(h_data_bram_din), m_din[0]); end
    if (m_wr[1]) begin chk("ni_addr", 32'(h_node_info_bram_addra), m_addr[1]); chk("ni_din", 32'(h_node_info_bram_din), m_din[1]); end
    if (m_wr[2]) begin chk("w_addr", 32'(wgt_bram_addra), m_addr[2]); chk("w_din", 32'(wgt_bram_din), m_din[2]); end
    wr_cnt += int'(h_data_bram_ena) + int'(h_node_info_bram_ena) + int'(wgt_bram_ena);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic beat(input int val, input logic last, input bit bp);
    bit ok = 0, acc;
    if (bp) for (int k = 0; k < 8 && $urandom_range(1) == 1; k++) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #2;
    end
    s_axis_tdata = ($urandom << 12) | 32'(val);
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      acc = s_axis_tready;
      @(posedge clk); #2;
      if (acc) begin ok = 1; break; end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout: beat 0x%0h never accepted", val);
    end
  endtask

  task automatic full_load(input bit bp);
    int w0 = wr_cnt;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < depth[r]; i++) beat(i + 16, i == depth[r] - 1, bp);
    @(negedge clk);
    chk("wdone_n1", 32'(wgt_bram_load_done), 0);
    @(negedge clk);
    chk("dones_n2", {29'd0, wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, 7);
    chk("idle_done", {30'd0, busy, s_axis_tready}, 0);
    chk("load_writes", wr_cnt - w0, 19);
    @(posedge clk); #2;
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 0; s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ctrl", {27'd0, s_axis_tready, busy, err, h_data_bram_load_done, wgt_bram_load_done}, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    pulse_start();
    full_load(0);
    s_axis_tdata = 16; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    pulse_start();
    chk("reload_clear", {28'd0, err, wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, 0);
    full_load(1);
    pulse_start();
    w0 = wr_cnt;
    beat(16, 0, 1); beat(17, 0, 1); beat(18, 1, 1);
    @(negedge clk);
    chk("early_err", {28'd0, err, s_axis_tready, busy, h_data_bram_load_done}, 8);
    chk("early_dones", {29'd0, wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done}, 0);
    chk("early_writes", wr_cnt - w0, 2);
    @(posedge clk); #2;
    pulse_start();
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) beat(i + 16, i == 3, 1);
    for (int i = 0; i < 3; i++) beat(i + 16, 0, 1);
    @(negedge clk);
    chk("miss_err", {29'd0, err, h_data_bram_load_done, h_node_info_bram_load_done}, 6);
    chk("miss_writes", wr_cnt - w0, 6);
    @(posedge clk); #2;
    pulse_start();
    for (int i = 0; i < 4; i++) beat(i + 16, i == 3, 0);
    beat(16, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {23'd0, s_axis_tready, busy, err, h_data_bram_load_done, h_node_info_bram_load_done,
        wgt_bram_load_done, h_data_bram_ena, h_node_info_bram_ena, wgt_bram_ena}, 0);
    chk("arst_addr", {24'd0, h_data_bram_addra, h_node_info_bram_addra, wgt_bram_addra}, 0);
    chk("arst_din", {3'd0, h_data_bram_din, h_node_info_bram_din, wgt_bram_din}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    w0 = wr_cnt;
    s_axis_tdata = 16; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      chk("post_rst_tready", 32'(s_axis_tready), 0);
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_writes", wr_cnt - w0, 0);
    @(posedge clk); #2;
    pulse_start();
    full_load(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
